// File: rtl/sevenseg_pkg.sv
// Shared types and the segment font for seven-segment capture and display.
// Font entries are active-low patterns, bit0 = segment a .. bit6 = segment g.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LATCHED
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry i is the glyph for nibble i; index 0 sits in the low bits.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic one_hot_low(input logic [7:0] an);
    return $onehot(~an);
  endfunction

  function automatic logic multi_low(input logic [7:0] an);
    return $countones(~an) > 1;
  endfunction

  function automatic logic [2:0] an_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sevenseg_capture_pattern_decode.sv
// Combinational segment-pattern to nibble lookup against the shared font.
// Any pattern outside the font (blank included) decodes to invalid, nibble 0.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_FONT[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Captures multiplexed seven-segment digits once the segment/anode lines settle.
// Define SEVENSEG_CAPTURE_DP_EN to also capture the decimal point per digit.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  hex,
  input  logic [7:0]  AN,
`ifdef SEVENSEG_CAPTURE_DP_EN
  input  logic        dp,
  output logic [7:0]  dp_out,
`endif
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic [7:0]  seen,
  output logic        frame_done,
  output logic        err_multi
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [6:0]  hex_q, hex_d, hex_p_q, hex_p_d;
  logic [7:0]  an_q, an_d, an_p_q, an_p_d;
  state_e      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  seen_q, seen_d;
  logic        fd_q, fd_d;
  logic        err_q, err_d;
  logic        changed;
  logic        latch;
  logic [2:0]  idx;
  logic        dec_valid;
  logic [3:0]  dec_nibble;

`ifdef SEVENSEG_CAPTURE_DP_EN
  logic       dp_q, dp_d, dp_p_q, dp_p_d;
  logic [7:0] dp_out_q, dp_out_d;
`endif

  sevenseg_pattern_decode u_decode (
    .pattern (hex_q),
    .valid   (dec_valid),
    .nibble  (dec_nibble)
  );

  // Input sampling plus a one-cycle history for change detection.
  always_comb begin
    hex_d   = hex;
    an_d    = AN;
    hex_p_d = hex_q;
    an_p_d  = an_q;
`ifdef SEVENSEG_CAPTURE_DP_EN
    dp_d    = dp;
    dp_p_d  = dp_q;
`endif
  end

  always_comb begin
    changed = (hex_q != hex_p_q) || (an_q != an_p_q);
`ifdef SEVENSEG_CAPTURE_DP_EN
    changed = changed || (dp_q != dp_p_q);
`endif
    state_d = state_q;
    count_d = count_q;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (one_hot_low(an_q)) begin
          state_d = SETTLE;
          count_d = 8'd1;
        end
      end
      SETTLE, LATCHED: begin
        if (changed) begin
          if (one_hot_low(an_q)) begin
            state_d = SETTLE;
            count_d = 8'd1;
          end else begin
            state_d = IDLE;
            count_d = 8'd0;
          end
        end else if (state_q == SETTLE) begin
          count_d = count_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 8'd0;
      end
    endcase
    if (state_d == SETTLE && count_d == STABLE) begin
      state_d = LATCHED;
      latch   = 1'b1;
    end
  end

  always_comb begin
    idx      = an_index(an_q);
    digits_d = digits_q;
    valid_d  = valid_q;
    seen_d   = fd_q ? 8'h00 : seen_q;
`ifdef SEVENSEG_CAPTURE_DP_EN
    dp_out_d = dp_out_q;
`endif
    if (latch) begin
      digits_d[{idx, 2'b00} +: 4] = dec_nibble;
      valid_d[idx]                = dec_valid;
      seen_d[idx]                 = 1'b1;
`ifdef SEVENSEG_CAPTURE_DP_EN
      dp_out_d[idx]               = ~dp_q;
`endif
    end
    fd_d  = latch && (seen_d == 8'hFF);
    err_d = (an_q != an_p_q) && multi_low(an_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q    <= SEG_BLANK;
      hex_p_q  <= SEG_BLANK;
      an_q     <= 8'hFF;
      an_p_q   <= 8'hFF;
      state_q  <= IDLE;
      count_q  <= 8'd0;
      digits_q <= 32'd0;
      valid_q  <= 8'd0;
      seen_q   <= 8'd0;
      fd_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hex_q    <= hex_d;
      hex_p_q  <= hex_p_d;
      an_q     <= an_d;
      an_p_q   <= an_p_d;
      state_q  <= state_d;
      count_q  <= count_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      fd_q     <= fd_d;
      err_q    <= err_d;
    end
  end

`ifdef SEVENSEG_CAPTURE_DP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_q     <= 1'b1;
      dp_p_q   <= 1'b1;
      dp_out_q <= 8'd0;
    end else begin
      dp_q     <= dp_d;
      dp_p_q   <= dp_p_d;
      dp_out_q <= dp_out_d;
    end
  end

  assign dp_out = dp_out_q;
`endif

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign seen        = seen_q;
  assign frame_done  = fd_q;
  assign err_multi   = err_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed and random checks of sevenseg_capture against a run-length model.
// The model latches a one-hot-low anode once its sample has persisted STABLE edges.
module tb_sevenseg_capture;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  hex;
  logic [7:0]  AN;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic [7:0]  seen;
  logic        frame_done;
  logic        err_multi;
`ifdef SEVENSEG_CAPTURE_DP_EN
  logic        dp;
  logic [7:0]  dp_out;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sevenseg_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .hex         (hex),
    .AN          (AN),
`ifdef SEVENSEG_CAPTURE_DP_EN
    .dp          (dp),
    .dp_out      (dp_out),
`endif
    .digits      (digits),
    .digit_valid (digit_valid),
    .seen        (seen),
    .frame_done  (frame_done),
    .err_multi   (err_multi)
  );

  logic [6:0] font [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model: sampled history plus how long the sample has persisted.
  logic [31:0] m_digits;
  logic [7:0]  m_valid, m_seen;
  logic        m_fd, m_err;
  logic [6:0]  h_cur, h_prev;
  logic [7:0]  a_cur, a_prev;
  int          run;
`ifdef SEVENSEG_CAPTURE_DP_EN
  logic        d_cur, d_prev;
  logic [7:0]  m_dp;
`endif

  task automatic model_reset();
    m_digits = '0; m_valid = '0; m_seen = '0;
    m_fd = 1'b0; m_err = 1'b0;
    h_cur = 7'h7F; h_prev = 7'h7F;
    a_cur = 8'hFF; a_prev = 8'hFF;
    run = 0;
`ifdef SEVENSEG_CAPTURE_DP_EN
    d_cur = 1'b1; d_prev = 1'b1; m_dp = '0;
`endif
  endtask

  task automatic model_edge();
    int  zeros, pos, nib;
    bit  same, ok;
    zeros = 0; pos = 0;
    for (int i = 0; i < 8; i++)
      if (!a_cur[i]) begin zeros++; pos = i; end
    m_err = (a_cur != a_prev) && (zeros >= 2);
    same = (h_cur == h_prev) && (a_cur == a_prev);
`ifdef SEVENSEG_CAPTURE_DP_EN
    same = same && (d_cur == d_prev);
`endif
    run = same ? run + 1 : 1;
    if (m_fd) m_seen = '0;
    m_fd = 1'b0;
    if (zeros == 1 && run == STABLE) begin
      ok = 0; nib = 0;
      for (int g = 0; g < 16; g++)
        if (font[g] == h_cur) begin ok = 1; nib = g; end
      m_digits[pos*4 +: 4] = 4'(nib);
      m_valid[pos] = ok;
      m_seen[pos] = 1'b1;
      m_fd = (m_seen == 8'hFF);
`ifdef SEVENSEG_CAPTURE_DP_EN
      m_dp[pos] = ~d_cur;
`endif
    end
    h_prev = h_cur; a_prev = a_cur;
    h_cur = hex; a_cur = AN;
`ifdef SEVENSEG_CAPTURE_DP_EN
    d_prev = d_cur; d_cur = dp;
`endif
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("digits", digits, m_digits);
    check("digit_valid", {24'd0, digit_valid}, {24'd0, m_valid});
    check("seen", {24'd0, seen}, {24'd0, m_seen});
    check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    check("err_multi", {31'd0, err_multi}, {31'd0, m_err});
`ifdef SEVENSEG_CAPTURE_DP_EN
    check("dp_out", {24'd0, dp_out}, {24'd0, m_dp});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digits"}, digits, 32'd0);
    check({tag, "_valid"}, {24'd0, digit_valid}, 32'd0);
    check({tag, "_seen"}, {24'd0, seen}, 32'd0);
    check({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_err"}, {31'd0, err_multi}, 32'd0);
`ifdef SEVENSEG_CAPTURE_DP_EN
    check({tag, "_dp"}, {24'd0, dp_out}, 32'd0);
`endif
  endtask

  initial begin
    int fd_count, err_count, a, b, r;
    rst = 1'b1; hex = 7'h7F; AN = 8'hFF;
`ifdef SEVENSEG_CAPTURE_DP_EN
    dp = 1'b1;
`endif
    model_reset();
    #12;
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Single digit 3 on anode 0: latch on edge STABLE+1.
    hex = 7'h30; AN = 8'hFE;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 4) check("r38_pre", {24'd0, digit_valid}, 32'd0);
      if (e == 5) begin
        check("r38_nib", {28'd0, digits[3:0]}, 32'd3);
        check("r38_valid", {31'd0, digit_valid[0]}, 32'd1);
        check("r38_seen", {24'd0, seen}, 32'h01);
      end
    end

    // Full scan 0..7 completes one frame.
    fd_count = 0;
    for (int d = 0; d < 8; d++) begin
      AN = ~(8'h01 << d); hex = font[d];
`ifdef SEVENSEG_CAPTURE_DP_EN
      dp = (d == 5) ? 1'b0 : 1'b1;
`endif
      repeat (6) begin tick(); if (frame_done) fd_count++; end
    end
    check("r39_fd_pulses", fd_count, 1);
    check("r39_digits", digits, 32'h76543210);
    check("r39_seen", {24'd0, seen}, 32'd0);
`ifdef SEVENSEG_CAPTURE_DP_EN
    check("r43_dp5", {24'd0, dp_out}, 32'h20);
    dp = 1'b1;
`endif
    AN = 8'hFF;
    repeat (2) tick();

    // Segment lines toggling faster than the settle window.
    AN = 8'hFD;
    for (int k = 0; k < 8; k++) begin
      hex = k[0] ? font[5] : font[6];
      repeat (3) tick();
    end
    check("r40_seen", {24'd0, seen}, 32'd0);
    check("r40_digit1", {28'd0, digits[7:4]}, 32'd1);

    // Two anodes at once, then a blank glyph on digit 2.
    AN = 8'hFC; hex = font[8]; err_count = 0;
    repeat (6) begin tick(); if (err_multi) err_count++; end
    check("r41_err_pulses", err_count, 1);
    check("r41_no_write", digits, 32'h76543210);
    AN = 8'hFB; hex = 7'h7F;
    repeat (5) tick();
    check("r41_valid", {24'd0, digit_valid}, 32'hFB);
    check("r41_nib2", {28'd0, digits[11:8]}, 32'd0);

    // Reset in the middle of a settle run.
    AN = 8'hF7; hex = font[9];
    repeat (3) tick();
    #2 rst = 1'b1;
    #1 check_zero("r42_async");
    model_reset();
    @(negedge clk); rst = 1'b0;
    repeat (4) tick();
    check("r42_no_early", {24'd0, seen}, 32'd0);
    tick();
    check("r42_seen", {24'd0, seen}, 32'h08);
    check("r42_digits", digits, 32'h00009000);

    // Random traffic against the model.
    repeat (80) begin
      r = $urandom_range(0, 9);
      if (r == 0) AN = 8'hFF;
      else if (r == 1) begin
        a = $urandom_range(0, 7);
        b = (a + 1 + $urandom_range(0, 6)) % 8;
        AN = ~((8'h01 << a) | (8'h01 << b));
      end else AN = ~(8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) hex = 7'($urandom);
      else hex = font[$urandom_range(0, 15)];
`ifdef SEVENSEG_CAPTURE_DP_EN
      dp = 1'($urandom);
`endif
      repeat ($urandom_range(1, 7)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
